// File: rtl/apb_i2c_pkg.sv
// Shared definitions for the APB register interface in front of i2c_master:
// register offsets, CTRL/STATUS bit positions, i2c_master state codes, FSM type.
package apb_i2c_pkg;

  localparam logic [7:0] ADDR_CTRL   = 8'h00;
  localparam logic [7:0] ADDR_TXDATA = 8'h04;
  localparam logic [7:0] ADDR_RXDATA = 8'h08;
  localparam logic [7:0] ADDR_STATUS = 8'h0C;

  localparam int CTRL_GO       = 0;
  localparam int CTRL_RW       = 1;
  localparam int CTRL_DA       = 2;
  localparam int CTRL_REP      = 3;
  localparam int CTRL_BC_LSB   = 4;
  localparam int CTRL_ADDR_LSB = 8;
  localparam int CTRL_IEN      = 16;

  // Stored CTRL bits; go is a strobe and is never held.
  localparam logic [31:0] CTRL_WMASK = 32'h0001_7F3E;

  localparam int ST_BUSY        = 0;
  localparam int ST_DONE        = 1;
  localparam int ST_NACK        = 2;
  localparam int ST_TIMEOUT     = 3;
  localparam int ST_ISTATE_LSB  = 4;
  localparam int ST_ISCOUNT_LSB = 8;

  localparam logic [3:0] I2C_IDLE   = 4'd0;
  localparam logic [3:0] I2C_START  = 4'd1;
  localparam logic [3:0] I2C_ADDR   = 4'd2;
  localparam logic [3:0] I2C_ACK    = 4'd3;
  localparam logic [3:0] I2C_WRITE  = 4'd4;
  localparam logic [3:0] I2C_READ   = 4'd5;
  localparam logic [3:0] I2C_MACK   = 4'd6;
  localparam logic [3:0] I2C_MNACK  = 4'd7;
  localparam logic [3:0] I2C_STOP   = 4'd8;
  localparam logic [3:0] I2C_RSTART = 4'd9;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_LAUNCH = 2'd1,
    S_RUN    = 2'd2,
    S_FINISH = 2'd3
  } regif_state_e;

endpackage

// File: rtl/apb_i2c_regif.sv
// Zero-wait-state APB register file plus launch/run/finish sequencer driving
// an i2c_master instance that sits beside it in the bridge top.
//
// state  | meaning
// IDLE   | no transfer, CTRL/TXDATA writable
// LAUNCH | enable high, waiting for i2c_master to leave its IDLE
// RUN    | master busy, watching for ACK->STOP (nack)
// FINISH | capture Dout into RXDATA, set done
module apb_i2c_regif
  import apb_i2c_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        psel,
  input  logic        penable,
  input  logic        pwrite,
  input  logic [7:0]  paddr,
  input  logic [31:0] pwdata,
  output logic [31:0] prdata,
  output logic        pready,
  output logic        pslverr,
  output logic        enable,
  output logic        rw,
  output logic        DA,
  output logic        rep,
  output logic [1:0]  bytcount,
  output logic [6:0]  addr,
  output logic [31:0] Din,
  input  logic [31:0] Dout,
  input  logic [3:0]  istate,
  input  logic [1:0]  iscount,
  output logic        irq
);

  localparam logic [4:0] TO_LIM  = 5'(TIMEOUT);
  localparam logic [4:0] TO_LAST = 5'(TIMEOUT - 1);

  regif_state_e state_q;
  logic [31:0]  ctrl_q;
  logic [31:0]  txdata_q;
  logic [31:0]  rxdata_q;
  logic         done_q;
  logic         nack_q;
  logic         timeout_q;
  logic         enable_q;
  logic [3:0]   prev_istate_q;
  logic [4:0]   tcnt_q;
  logic [4:0]   tcnt_d;

  logic        busy;
  logic        access;
  logic        mapped;
  logic        err;
  logic        wr_ok;
  logic        wr_ctrl;
  logic        wr_tx;
  logic        wr_status;
  logic        go;
  logic [31:0] status_w;

  assign busy   = (state_q != S_IDLE);
  assign access = psel & penable;
  assign mapped = (paddr == ADDR_CTRL) || (paddr == ADDR_TXDATA) ||
                  (paddr == ADDR_RXDATA) || (paddr == ADDR_STATUS);

  always_comb begin
    err = 1'b0;
    if (paddr[1:0] != 2'b00 || !mapped) err = 1'b1;
    else if (pwrite && paddr == ADDR_RXDATA) err = 1'b1;
    else if (pwrite && busy && (paddr == ADDR_CTRL || paddr == ADDR_TXDATA)) err = 1'b1;
  end

  assign wr_ok     = access & pwrite & ~err;
  assign wr_ctrl   = wr_ok & (paddr == ADDR_CTRL);
  assign wr_tx     = wr_ok & (paddr == ADDR_TXDATA);
  assign wr_status = wr_ok & (paddr == ADDR_STATUS);
  assign go        = wr_ctrl & pwdata[CTRL_GO];

  assign pready  = 1'b1;
  assign pslverr = access & err;

  assign status_w = {22'd0, iscount, istate, timeout_q, nack_q, done_q, busy};

  always_comb begin
    prdata = '0;
    if (psel) begin
      case (paddr)
        ADDR_CTRL:   prdata = ctrl_q;
        ADDR_TXDATA: prdata = txdata_q;
        ADDR_RXDATA: prdata = rxdata_q;
        ADDR_STATUS: prdata = status_w;
        default:     prdata = '0;
      endcase
    end
  end

  assign tcnt_d = (tcnt_q == TO_LIM) ? tcnt_q : tcnt_q + 5'd1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= S_IDLE;
      ctrl_q        <= '0;
      txdata_q      <= '0;
      rxdata_q      <= '0;
      done_q        <= 1'b0;
      nack_q        <= 1'b0;
      timeout_q     <= 1'b0;
      enable_q      <= 1'b0;
      prev_istate_q <= '0;
      tcnt_q        <= '0;
    end else begin
      prev_istate_q <= istate;
      if (wr_ctrl) ctrl_q <= pwdata & CTRL_WMASK;
      if (wr_tx) txdata_q <= pwdata;
      // Clears come first so a same-cycle hardware set below wins.
      if (wr_status) begin
        if (pwdata[ST_DONE])    done_q    <= 1'b0;
        if (pwdata[ST_NACK])    nack_q    <= 1'b0;
        if (pwdata[ST_TIMEOUT]) timeout_q <= 1'b0;
      end
      case (state_q)
        S_IDLE: begin
          if (go) begin
            state_q   <= S_LAUNCH;
            enable_q  <= 1'b1;
            tcnt_q    <= '0;
            done_q    <= 1'b0;
            nack_q    <= 1'b0;
            timeout_q <= 1'b0;
          end
        end
        S_LAUNCH: begin
          if (istate != I2C_IDLE) begin
            state_q  <= S_RUN;
            enable_q <= 1'b0;
          end else begin
            tcnt_q <= tcnt_d;
            if (tcnt_q >= TO_LAST) begin
              timeout_q <= 1'b1;
              enable_q  <= 1'b0;
              state_q   <= S_IDLE;
            end
          end
        end
        S_RUN: begin
          if (prev_istate_q == I2C_ACK && istate == I2C_STOP) nack_q <= 1'b1;
          if (istate == I2C_IDLE) state_q <= S_FINISH;
        end
        S_FINISH: begin
          rxdata_q <= Dout;
          done_q   <= 1'b1;
          state_q  <= S_IDLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign enable   = enable_q;
  assign rw       = ctrl_q[CTRL_RW];
  assign DA       = ctrl_q[CTRL_DA];
  assign rep      = ctrl_q[CTRL_REP];
  assign bytcount = ctrl_q[CTRL_BC_LSB +: 2];
  assign addr     = ctrl_q[CTRL_ADDR_LSB +: 7];
  assign Din      = txdata_q;
  assign irq      = done_q & ctrl_q[CTRL_IEN];

endmodule

// File: tb/tb_apb_i2c_regif.sv
// Scoreboard bench for apb_i2c_regif: stimulus queues expected APB responses
// and pin snapshots; a negedge monitor pops and compares them.
module tb_apb_i2c_regif;
  import apb_i2c_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0]  paddr = '0;
  logic [31:0] pwdata = '0;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic        enable, rw, DA, rep, irq;
  logic [1:0]  bytcount;
  logic [6:0]  addr;
  logic [31:0] Din;
  logic [31:0] Dout = '0;
  logic [3:0]  istate = '0;
  logic [1:0]  iscount = '0;

  apb_i2c_regif #(.TIMEOUT(16)) dut (
    .clk(clk), .rst(rst), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .enable(enable), .rw(rw), .DA(DA), .rep(rep),
    .bytcount(bytcount), .addr(addr), .Din(Din), .Dout(Dout),
    .istate(istate), .iscount(iscount), .irq(irq)
  );

  always #5 clk = ~clk;

  typedef struct { string name; logic [31:0] exp; logic [31:0] mask; logic exp_err; } apb_exp_t;
  typedef struct { string name; logic [63:0] exp; logic [63:0] mask; } pin_exp_t;

  localparam logic [63:0] M_EN  = 64'h0000_0000_0000_2000;
  localparam logic [63:0] M_IRQ = 64'h0000_0000_0000_1000;
  localparam logic [63:0] M_CTL = 64'h0000_0000_0000_0FFF;
  localparam logic [63:0] M_DIN = 64'hFFFF_FFFF_0000_0000;

  apb_exp_t apb_q[$];
  pin_exp_t pin_q[$];
  int   errors = 0;
  int   checks = 0;
  logic pin_stb = 1'b0;

  logic [3:0] wseq [12] = '{4'd1, 4'd2, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd3, 4'd4, 4'd6, 4'd8};
  logic [3:0] rseq [8]  = '{4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd5, 4'd7, 4'd8};
  logic [3:0] nseq [4]  = '{4'd1, 4'd2, 4'd3, 4'd8};

  function automatic logic [63:0] pin_vec();
    return {Din, 18'd0, enable, irq, rw, DA, rep, bytcount, addr};
  endfunction

  always @(negedge clk) begin : monitor
    apb_exp_t ea;
    pin_exp_t ep;
    logic [63:0] pv;
    if (psel && penable) begin
      checks++;
      if (apb_q.size() == 0) begin
        errors++;
        $display("FAIL apb_unexpected: access at paddr=%h with nothing expected", paddr);
      end else begin
        ea = apb_q.pop_front();
        if (pready !== 1'b1 || pslverr !== ea.exp_err || ((prdata & ea.mask) !== (ea.exp & ea.mask))) begin
          errors++;
          $display("FAIL %s: got prdata=%h pslverr=%b pready=%b, want prdata=%h (mask %h) pslverr=%b pready=1",
                   ea.name, prdata, pslverr, pready, ea.exp, ea.mask, ea.exp_err);
        end
      end
    end
    if (pin_stb) begin
      checks++;
      if (pin_q.size() == 0) begin
        errors++;
        $display("FAIL pin_unexpected: pin strobe with nothing expected");
      end else begin
        ep = pin_q.pop_front();
        pv = pin_vec();
        if ((pv & ep.mask) !== (ep.exp & ep.mask)) begin
          errors++;
          $display("FAIL %s: got pins=%h, want %h (mask %h)", ep.name, pv & ep.mask, ep.exp & ep.mask, ep.mask);
        end
      end
    end
  end

  task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input logic err, input string nm);
    apb_q.push_back('{nm, 32'h0, 32'h0, err});
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; paddr = a; pwdata = d; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [7:0] a, input logic [31:0] exp, input logic err, input string nm);
    apb_q.push_back('{nm, exp, err ? 32'h0 : 32'hFFFF_FFFF, err});
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; paddr = a; penable = 1'b0;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pin_chk(input string nm, input logic [63:0] exp, input logic [63:0] mask);
    pin_q.push_back('{nm, exp, mask});
    pin_stb = 1'b1;
    @(negedge clk); #1;
    pin_stb = 1'b0;
  endtask

  task automatic step(input logic [3:0] s, input logic [1:0] c);
    @(posedge clk); #1;
    istate = s; iscount = c;
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit expired");
    $fatal(1, "time limit");
  end

  initial begin : stim
    repeat (3) @(posedge clk);
    #1;
    pin_chk("reset_pins", 64'h0, M_EN | M_IRQ | M_CTL | M_DIN);
    rst = 1'b0;
    apb_read(ADDR_CTRL,   32'h0, 1'b0, "reset_ctrl");
    apb_read(ADDR_TXDATA, 32'h0, 1'b0, "reset_tx");
    apb_read(ADDR_RXDATA, 32'h0, 1'b0, "reset_rx");
    apb_read(ADDR_STATUS, 32'h0, 1'b0, "reset_status");

    // write transfer, ACKing slave, ien set
    Dout = 32'hCAFE_0001;
    apb_write(ADDR_TXDATA, 32'hA5A5_5A5A, 1'b0, "wr_tx");
    apb_read(ADDR_TXDATA, 32'hA5A5_5A5A, 1'b0, "rd_tx");
    apb_write(ADDR_CTRL, 32'h0001_5031, 1'b0, "wr_ctrl_go");
    apb_read(ADDR_CTRL, 32'h0001_5030, 1'b0, "ctrl_go_reads0");
    pin_chk("launch_pins", {32'hA5A5_5A5A, 32'h0000_21D0}, M_EN | M_CTL | M_DIN);
    apb_read(ADDR_STATUS, 32'h1, 1'b0, "launch_busy");
    foreach (wseq[i]) step(wseq[i], 2'd0);
    apb_read(ADDR_STATUS, 32'h81, 1'b0, "run_status");
    step(4'd4, 2'd2);
    apb_read(ADDR_STATUS, 32'h241, 1'b0, "run_live_istate");
    pin_chk("run_enable_low", 64'h0, M_EN);
    step(4'd6, 2'd0);
    step(4'd0, 2'd0);
    repeat (2) @(posedge clk);
    apb_read(ADDR_STATUS, 32'h2, 1'b0, "wr_done");
    apb_read(ADDR_RXDATA, 32'hCAFE_0001, 1'b0, "wr_rxdata");
    pin_chk("irq_high", M_IRQ, M_IRQ | M_EN);
    apb_write(ADDR_STATUS, 32'h2, 1'b0, "w1c_done");
    apb_read(ADDR_STATUS, 32'h0, 1'b0, "done_cleared");
    pin_chk("irq_low", 64'h0, M_IRQ);

    // read transfer, ien clear, W1C of done on the same edge done is set
    Dout = 32'h1234_0000;
    apb_write(ADDR_CTRL, 32'h0000_5017, 1'b0, "rd_ctrl_go");
    pin_chk("rd_pins", {32'hA5A5_5A5A, 32'h0000_2CD0}, M_EN | M_CTL | M_DIN);
    apb_read(ADDR_CTRL, 32'h0000_5016, 1'b0, "rd_ctrl_read");
    foreach (rseq[i]) step(rseq[i], 2'd1);
    fork
      apb_write(ADDR_STATUS, 32'h2, 1'b0, "w1c_vs_set");
      begin
        @(posedge clk); #1;
        istate = 4'd0; iscount = 2'd0;
      end
    join
    apb_read(ADDR_STATUS, 32'h2, 1'b0, "set_wins_over_w1c");
    apb_read(ADDR_RXDATA, 32'h1234_0000, 1'b0, "rd_rxdata");
    pin_chk("rd_irq_masked", 64'h0, M_IRQ);

    // no slave: ACK followed by STOP flags nack
    apb_write(ADDR_CTRL, 32'h0000_5001, 1'b0, "nk_ctrl_go");
    foreach (nseq[i]) step(nseq[i], 2'd0);
    step(4'd0, 2'd0);
    repeat (2) @(posedge clk);
    apb_read(ADDR_STATUS, 32'h6, 1'b0, "nack_done");
    apb_write(ADDR_STATUS, 32'h4, 1'b0, "w1c_nack");
    apb_read(ADDR_STATUS, 32'h2, 1'b0, "nack_cleared");

    // istate stuck at 0: timeout after exactly 16 LAUNCH cycles
    apb_write(ADDR_CTRL, 32'h0000_5001, 1'b0, "to_ctrl_go");
    pin_chk("to_enable_start", M_EN, M_EN);
    repeat (14) @(posedge clk);
    pin_chk("to_enable_c14", M_EN, M_EN);
    @(posedge clk);
    pin_chk("to_enable_c15", M_EN, M_EN);
    @(posedge clk);
    pin_chk("to_enable_c16", 64'h0, M_EN);
    apb_read(ADDR_STATUS, 32'h8, 1'b0, "timeout_status");

    // error responses while a transfer is running
    step(4'd1, 2'd0);
    apb_write(ADDR_CTRL, 32'h0000_5001, 1'b0, "err_ctrl_go");
    apb_write(ADDR_CTRL, 32'h0, 1'b1, "err_ctrl_busy");
    apb_write(ADDR_CTRL, 32'h0000_5017, 1'b1, "err_go_busy");
    apb_write(ADDR_TXDATA, 32'h1111_1111, 1'b1, "err_tx_busy");
    apb_write(ADDR_RXDATA, 32'h1, 1'b1, "err_rx_write");
    apb_read(8'h10, 32'h0, 1'b1, "err_unmapped");
    apb_read(8'h02, 32'h0, 1'b1, "err_misaligned_rd");
    apb_write(8'h0D, 32'hE, 1'b1, "err_misaligned_wr");
    apb_read(ADDR_CTRL, 32'h0000_5000, 1'b0, "err_ctrl_kept");
    apb_read(ADDR_TXDATA, 32'hA5A5_5A5A, 1'b0, "err_tx_kept");
    apb_read(ADDR_STATUS, 32'h11, 1'b0, "err_run_kept");
    pin_chk("err_pins", 64'h0000_0000_0000_0050, M_EN | M_CTL);

    // asynchronous reset in RUN
    @(posedge clk); #2;
    rst = 1'b1;
    pin_chk("rst_run_pins", 64'h0, M_EN | M_IRQ | M_CTL | M_DIN);
    Dout = 32'hFFFF_FFFF;
    istate = 4'd0;
    apb_read(ADDR_CTRL, 32'h0, 1'b0, "rst_ctrl");
    apb_read(ADDR_TXDATA, 32'h0, 1'b0, "rst_tx");
    rst = 1'b0;
    repeat (3) @(posedge clk);
    apb_read(ADDR_STATUS, 32'h0, 1'b0, "rst_no_done");
    apb_read(ADDR_RXDATA, 32'h0, 1'b0, "rst_no_rx");
    pin_chk("rst_after_pins", 64'h0, M_EN | M_IRQ);

    checks++;
    if (apb_q.size() != 0 || pin_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: apb left=%0d pin left=%0d, want 0 and 0", apb_q.size(), pin_q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/apb_i2c_regif.md
APB_I2C_REGIF -- requirements
Module: apb_i2c_regif

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: maximum clk cycles spent in LAUNCH before an error is flagged.
REQ-002 SHALL have ports clk (input, 1) as the single clock and rst (input, 1) as the asynchronous active-high reset.
REQ-003 SHALL have APB slave inputs psel, penable and pwrite (1 bit each), paddr (8 bits) and pwdata (32 bits).
REQ-004 SHALL have APB slave outputs prdata (32 bits), pready (1 bit) and pslverr (1 bit).
REQ-005 SHALL have outputs toward i2c_master: enable (1), rw (1), DA (1), rep (1), bytcount (2), addr (7) and Din (32).
REQ-006 SHALL have inputs from i2c_master: Dout (32), istate (4) and iscount (2).
REQ-007 SHALL have output irq (1 bit), equal to the done bit AND ien.

Function
REQ-008 SHALL complete every APB access in zero wait states: pready is held at 1, writes commit on psel&penable&pwrite, and reads return prdata combinationally during psel.
REQ-009 SHALL implement the register map:
 - 0x00 CTRL: bit0 go (write-1, self-clearing, reads 0), bit1 rw, bit2 DA, bit3 rep, bits5:4 bytcount, bits14:8 addr, bit16 ien.
 - 0x04 TXDATA: drives Din.
 - 0x08 RXDATA: read-only.
 - 0x0C STATUS: bit0 busy, bit1 done, bit2 nack, bit3 timeout, bits7:4 istate (live), bits9:8 iscount (live).
 - Writing 1 to any of STATUS bits 1..3 clears that bit.
REQ-010 SHALL drive pslverr=1, with no state change, for: paddr[1:0]!=0; an unmapped address; a write to RXDATA; a write to CTRL or TXDATA while busy.
REQ-011 SHALL drive rw, DA, rep, bytcount and addr directly from the CTRL fields, and Din directly from TXDATA.
REQ-012 SHALL implement the FSM states IDLE, LAUNCH, RUN and FINISH.
REQ-013 IDLE -> LAUNCH SHALL occur on a CTRL write with go=1 while not busy; in the same edge, done, nack and timeout are cleared.
REQ-014 In LAUNCH, enable SHALL be 1. The FSM moves to RUN when istate!=0. If instead TIMEOUT cycles elapse with istate==0, it sets timeout and returns to IDLE.
REQ-015 In RUN, enable SHALL be 0. The FSM moves to FINISH when istate==0.
REQ-016 In FINISH (one cycle), the block SHALL load RXDATA<=Dout, set done, and return to IDLE.
REQ-017 busy SHALL equal 1 in every state except IDLE.
REQ-018 The block SHALL register istate every cycle as prev_istate, and set nack when prev_istate==3 (ACK) and istate==8 (STOP) while in RUN.
REQ-019 A STATUS write-1-to-clear in the same cycle as a hardware set of the same bit SHALL leave the bit set.
REQ-020 The timeout counter SHALL be 5 bits wide, reset to 0 on LAUNCH entry, and saturate at TIMEOUT.
REQ-021 A go written while busy SHALL be rejected per REQ-010 and SHALL leave the running transfer undisturbed.

Reset
REQ-022 On rst=1, asynchronously, the block SHALL set:
 - state to IDLE;
 - CTRL, TXDATA, RXDATA and the done, nack and timeout bits to 0;
 - enable, irq and pslverr to 0;
 - prev_istate and the timeout counter to 0.
REQ-023 A reset asserted mid-transfer SHALL force enable to 0 immediately; no RXDATA update and no done set SHALL follow.

Structure
REQ-024 A shared package apb_i2c_pkg SHALL hold:
 - the register offsets (0x00, 0x04, 0x08, 0x0C);
 - the CTRL and STATUS bit positions;
 - the i2c_master state encodings IDLE=0 through RSTART=9;
 - the FSM state type.
REQ-025 The design SHALL be a single module with no sub-modules; it is instantiated beside i2c_master in the bridge top.

Verification
REQ-026 Write TXDATA=0xA5A55A5A, then CTRL go=1, rw=0, bytcount=3, addr=0x50, with an ACKing slave model -> enable high until istate!=0, then done=1, irq=1 when ien=1, and the slave receives A5 A5 5A 5A.
REQ-027 Run a read with rw=1, DA=1, bytcount=1, and a slave returning 0x12,0x34 -> RXDATA=0x12340000 and done=1.
REQ-028 Address with no slave (SDA held high) -> nack=1, done=1, busy=0.
REQ-029 Tie istate to 0 and write go -> timeout=1 after 16 cycles, enable low and busy=0.
REQ-030 Write CTRL while busy, or read 0x10, or access paddr=0x02 -> pslverr=1 and registers unchanged.
REQ-031 Assert rst during RUN -> enable=0 and all registers at reset values in the same cycle, with no done afterwards.
